// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared state encoding and RGB565 pixel format for the camera capture path
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_BLANK = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_CAPTURE    = 3'd3,
    ST_DONE       = 3'd4
  } cam_state_e;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIXEL_W = RGB_R_W + RGB_G_W + RGB_B_W;

  typedef struct packed {
    logic [RGB_R_W-1:0] r;
    logic [RGB_G_W-1:0] g;
    logic [RGB_B_W-1:0] b;
  } rgb565_t;

  // The sensor sends the red/high byte first.
  localparam bit FIRST_BYTE_HIGH = 1'b1;

  function automatic logic [PIXEL_W-1:0] pack_pixel(input logic [7:0] first,
                                                    input logic [7:0] second);
    return FIRST_BYTE_HIGH ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/cam_pixel_pack.sv
// rtl/cam_pixel_pack.sv - pairs href-qualified camera bytes into 16-bit pixels and flags odd-length runs
module cam_pixel_pack
  import cam_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        en_i,
  input  logic        href_i,
  input  logic [7:0]  dat_i,
  output logic        pix_valid_o,
  output logic [15:0] pixel_o,
  output logic        line_end_o,
  output logic        odd_o
);

  logic       href_q, href_d;
  logic       phase_q, phase_d;
  logic [7:0] held_q, held_d;

  always_comb begin
    href_d  = en_i & href_i;
    phase_d = (en_i & href_i) ? ~phase_q : 1'b0;
    held_d  = (en_i & href_i & ~phase_q) ? dat_i : held_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      href_q  <= 1'b0;
      phase_q <= 1'b0;
      held_q  <= 8'h00;
    end else begin
      href_q  <= href_d;
      phase_q <= phase_d;
      held_q  <= held_d;
    end
  end

  // phase_q is still 1 on the falling-edge cycle when the run had an odd byte count.
  assign pix_valid_o = en_i & href_i & phase_q;
  assign pixel_o     = pack_pixel(held_q, dat_i);
  assign line_end_o  = en_i & href_q & ~href_i;
  assign odd_o       = line_end_o & phase_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - one-frame camera capture sequencer with window crop and frame-buffer write port
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int COL_START  = 0,
  parameter int COLS       = 64,
  parameter int ROW_START  = 0,
  parameter int ROWS       = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [7:0]            cam_dat,
  output logic                  cam_dat_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_short,
  output logic                  err_odd
);

  localparam int COL_END  = COL_START + COLS;
  localparam int ROW_END  = ROW_START + ROWS;
  localparam int ROW_LAST = ROW_END - 1;

  cam_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  col_q, col_d, row_q, row_d;
  logic [ADDR_WIDTH-1:0] pix_addr_q, pix_addr_d, wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  err_short_q, err_short_d, err_odd_q, err_odd_d;

  logic        capture, abort_hit, arm, in_win, last_line;
  logic        pix_valid, line_end, odd_run;
  logic [15:0] pixel;
  int          col_int, row_int;

  cam_pixel_pack u_pack (
    .clk         (clk),
    .resetn      (resetn),
    .en_i        (capture),
    .href_i      (cam_href),
    .dat_i       (cam_dat),
    .pix_valid_o (pix_valid),
    .pixel_o     (pixel),
    .line_end_o  (line_end),
    .odd_o       (odd_run)
  );

  assign capture   = (state_q == ST_CAPTURE);
  assign abort_hit = abort && (state_q != ST_IDLE);
  assign arm       = start && !abort_hit && (state_q == ST_IDLE || state_q == ST_DONE);
  assign col_int   = int'(col_q);
  assign row_int   = int'(row_q);
  // Window test uses the column of the pixel being completed, before col increments.
  assign in_win    = (row_int >= ROW_START) && (row_int < ROW_END) &&
                     (col_int >= COL_START) && (col_int < COL_END);
  assign last_line = line_end && (row_int == ROW_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start)      state_d = ST_WAIT_BLANK;
        ST_WAIT_BLANK:    if (cam_vsync)  state_d = ST_WAIT_START;
        ST_WAIT_START:    if (!cam_vsync) state_d = ST_CAPTURE;
        ST_CAPTURE:       if (last_line || cam_vsync) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cam_dat_en = (state_q == ST_WAIT_START) || (state_q == ST_CAPTURE);
    busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done       = (state_q == ST_DONE);
    wr_en      = wr_en_q && !abort_hit;
  end

  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign err_short = err_short_q;
  assign err_odd   = err_odd_q;

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pix_addr_d  = pix_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_short_d = err_short_q;
    err_odd_d   = err_odd_q;
    if (!capture) begin
      col_d      = '0;
      row_d      = '0;
      pix_addr_d = '0;
    end else begin
      if (line_end) begin
        col_d = '0;
        if (row_q != '1) row_d = row_q + CNT_WIDTH'(1);
      end else if (pix_valid) begin
        if (col_q != '1) col_d = col_q + CNT_WIDTH'(1);
        if (in_win && !abort_hit) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pix_addr_q;
          wr_data_d = pixel;
          if (pix_addr_q != '1) pix_addr_d = pix_addr_q + ADDR_WIDTH'(1);
        end
      end
      if (odd_run && !abort_hit) err_odd_d = 1'b1;
      // A completing line wins over a coincident vsync rise.
      if (cam_vsync && !last_line && !abort_hit) err_short_d = 1'b1;
    end
    if (arm) begin
      err_short_d = 1'b0;
      err_odd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q       <= '0;
      row_q       <= '0;
      pix_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 16'h0000;
      err_short_q <= 1'b0;
      err_odd_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pix_addr_q  <= pix_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_short_q <= err_short_d;
      err_odd_q   <= err_odd_d;
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - randomized self-checking bench for cam_capture_ctrl (full window and cropped instance)
module tb_cam_capture_ctrl;

  localparam int AW = 11;

  logic clk = 1'b0;
  logic resetn, start, abort, cam_vsync, cam_href;
  logic [7:0] cam_dat;
  logic [1:0] den_v, wr_en_v, busy_v, done_v, es_v, eo_v;
  logic [AW-1:0] wr_addr_v [2];
  logic [15:0]   wr_data_v [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_capture_ctrl #(.COL_START(0), .COLS(4), .ROW_START(0), .ROWS(2),
                     .ADDR_WIDTH(AW), .CNT_WIDTH(11)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_dat(cam_dat),
    .cam_dat_en(den_v[0]), .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0]),
    .wr_data(wr_data_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .err_short(es_v[0]), .err_odd(eo_v[0]));

  cam_capture_ctrl #(.COL_START(2), .COLS(4), .ROW_START(1), .ROWS(2),
                     .ADDR_WIDTH(AW), .CNT_WIDTH(11)) u_crop (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_dat(cam_dat),
    .cam_dat_en(den_v[1]), .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1]),
    .wr_data(wr_data_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .err_short(es_v[1]), .err_odd(eo_v[1]));

  function automatic int win_cs(input int d); return (d == 0) ? 0 : 2; endfunction
  function automatic int win_rs(input int d); return (d == 0) ? 0 : 1; endfunction
  localparam int WIN_COLS = 4;
  localparam int WIN_ROWS = 2;

  logic [26:0] got_w [2][512];
  int          wr_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (wr_en_v[d] === 1'b1) begin
        if (wr_cnt[d] < 512) got_w[d][wr_cnt[d]] <= {wr_addr_v[d], wr_data_v[d]};
        wr_cnt[d] <= wr_cnt[d] + 1;
      end
  end

  int          f_len[$];
  logic [7:0]  f_byte[$];
  logic [26:0] exp_w [2][512];
  int          exp_n [2];
  bit          exp_short [2], exp_odd [2];
  int          cut_cnt [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    f_len.delete();
    f_byte.delete();
  endtask

  task automatic add_line(input int n, input bit ramp);
    f_len.push_back(n);
    for (int i = 0; i < n; i++) f_byte.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
  endtask

  // Reference: pixels are byte pairs within a line, a trailing odd byte is lost,
  // windowed pixels are numbered in arrival order, and the frame ends after the last window row.
  task automatic run_model(input int d);
    int  base, addr;
    bit  fin;
    base = 0; addr = 0; fin = 0;
    exp_n[d] = 0; exp_odd[d] = 0;
    for (int r = 0; r < f_len.size() && !fin; r++) begin
      if (f_len[r] % 2 == 1) exp_odd[d] = 1;
      for (int p = 0; p < f_len[r] / 2; p++)
        if (r >= win_rs(d) && r < win_rs(d) + WIN_ROWS &&
            p >= win_cs(d) && p < win_cs(d) + WIN_COLS) begin
          exp_w[d][exp_n[d]] = {AW'(addr), f_byte[base + 2*p], f_byte[base + 2*p + 1]};
          addr++;
          exp_n[d]++;
        end
      if (r == win_rs(d) + WIN_ROWS - 1) fin = 1;
      base += f_len[r];
    end
    exp_short[d] = !fin;
  endtask

  task automatic send_frame(input int ab_line, input int ab_byte, input int rs_line, input int rs_byte);
    int idx;
    idx = 0;
    cam_href = 0; cam_vsync = 1;
    repeat (4) tick();
    cam_vsync = 0;
    repeat (3) tick();
    for (int l = 0; l < f_len.size(); l++) begin
      for (int b = 0; b < f_len[l]; b++) begin
        cam_href = 1;
        cam_dat  = f_byte[idx];
        idx++;
        if (l == ab_line && b == ab_byte) begin
          abort = 1;
          cut_cnt = wr_cnt;
        end
        if (l == rs_line && b == rs_byte) begin
          resetn = 0;
          cut_cnt = wr_cnt;
        end
        tick();
        abort = 0;
        resetn = 1;
      end
      cam_href = 0; cam_dat = 8'h00;
      repeat ($urandom_range(2, 5)) tick();
    end
    cam_vsync = 1;
    repeat (3) tick();
    cam_vsync = 0;
    tick();
  endtask

  task automatic test_reset();
    resetn = 0; start = 0; abort = 0; cam_vsync = 0; cam_href = 0; cam_dat = 8'h00;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({den_v[d], wr_en_v[d], busy_v[d], done_v[d], es_v[d], eo_v[d], wr_addr_v[d], wr_data_v[d]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got busy=%b done=%b den=%b wr_en=%b, required all 0", d, busy_v[d], done_v[d], den_v[d], wr_en_v[d]);
      end
    end
    resetn = 1;
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({den_v[d], wr_en_v[d], busy_v[d], done_v[d], es_v[d], eo_v[d]} !== 6'b0) begin
        errors++;
        $display("FAIL idle_after_reset dut%0d: got busy=%b done=%b den=%b, required 0", d, busy_v[d], done_v[d], den_v[d]);
      end
    end
  endtask

  task automatic test_nominal();
    int base [2];
    new_frame();
    repeat (3) add_line(10, 1'b1);
    run_model(0); run_model(1);
    base = wr_cnt;
    start = 1; tick(); start = 0;
    checks++;
    if (busy_v !== 2'b11 || den_v !== 2'b00) begin
      errors++;
      $display("FAIL nominal_arm: got busy=%b den=%b, required busy=11 den=00", busy_v, den_v);
    end
    send_frame(-1, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wr_cnt[d] - base[d] !== exp_n[d]) begin
        errors++;
        $display("FAIL nominal_count dut%0d: got %0d writes, required %0d", d, wr_cnt[d] - base[d], exp_n[d]);
      end
      for (int i = 0; i < exp_n[d] && base[d] + i < wr_cnt[d]; i++) begin
        checks++;
        if (got_w[d][base[d] + i] !== exp_w[d][i]) begin
          errors++;
          $display("FAIL nominal_write%0d dut%0d: got %h, required %h", i, d, got_w[d][base[d] + i], exp_w[d][i]);
        end
      end
      checks++;
      if ({done_v[d], es_v[d], eo_v[d], busy_v[d]} !== {1'b1, exp_short[d], exp_odd[d], 1'b0}) begin
        errors++;
        $display("FAIL nominal_status dut%0d: got done=%b es=%b eo=%b busy=%b, required done=1 es=%b eo=%b busy=0",
                 d, done_v[d], es_v[d], eo_v[d], busy_v[d], exp_short[d], exp_odd[d]);
      end
    end
    if (wr_cnt[0] > base[0]) begin
      checks++;
      if (got_w[0][base[0]] !== {11'd0, 16'h0001}) begin
        errors++;
        $display("FAIL nominal_first dut0: got %h, required %h", got_w[0][base[0]], {11'd0, 16'h0001});
      end
    end
    if (wr_cnt[1] > base[1]) begin
      checks++;
      if (got_w[1][base[1]] !== {11'd0, 16'h0405}) begin
        errors++;
        $display("FAIL crop_first dut1: got %h, required %h", got_w[1][base[1]], {11'd0, 16'h0405});
      end
    end
  endtask

  task automatic test_arm_midframe();
    int base [2];
    new_frame();
    repeat (3) add_line(10, 1'b0);
    run_model(0); run_model(1);
    base = wr_cnt;
    cam_vsync = 0;
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < 10; b++) begin
        cam_href = 1; cam_dat = 8'($urandom_range(0, 255));
        start = (l == 1 && b == 3);
        tick();
        start = 0;
      end
      cam_href = 0;
      repeat (3) tick();
    end
    checks++;
    if (wr_cnt[0] != base[0] || wr_cnt[1] != base[1] || busy_v !== 2'b11 || den_v !== 2'b00) begin
      errors++;
      $display("FAIL midframe_hold: got writes=%0d/%0d busy=%b den=%b, required 0/0 11 00",
               wr_cnt[0] - base[0], wr_cnt[1] - base[1], busy_v, den_v);
    end
    send_frame(-1, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wr_cnt[d] - base[d] !== exp_n[d]) begin
        errors++;
        $display("FAIL midframe_count dut%0d: got %0d writes, required %0d", d, wr_cnt[d] - base[d], exp_n[d]);
      end
      for (int i = 0; i < exp_n[d] && base[d] + i < wr_cnt[d]; i++) begin
        checks++;
        if (got_w[d][base[d] + i] !== exp_w[d][i]) begin
          errors++;
          $display("FAIL midframe_write%0d dut%0d: got %h, required %h", i, d, got_w[d][base[d] + i], exp_w[d][i]);
        end
      end
    end
  endtask

  task automatic test_short_and_odd(input bit odd_case);
    int base [2];
    new_frame();
    if (odd_case) begin
      add_line(9, 1'b0); add_line(10, 1'b0); add_line(10, 1'b0);
    end else begin
      add_line(10, 1'b0);
    end
    run_model(0); run_model(1);
    base = wr_cnt;
    start = 1; tick(); start = 0;
    send_frame(-1, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wr_cnt[d] - base[d] !== exp_n[d]) begin
        errors++;
        $display("FAIL %s_count dut%0d: got %0d writes, required %0d", odd_case ? "odd" : "short", d, wr_cnt[d] - base[d], exp_n[d]);
      end
      for (int i = 0; i < exp_n[d] && base[d] + i < wr_cnt[d]; i++) begin
        checks++;
        if (got_w[d][base[d] + i] !== exp_w[d][i]) begin
          errors++;
          $display("FAIL %s_write%0d dut%0d: got %h, required %h", odd_case ? "odd" : "short", i, d, got_w[d][base[d] + i], exp_w[d][i]);
        end
      end
      checks++;
      if ({done_v[d], es_v[d], eo_v[d]} !== {1'b1, exp_short[d], exp_odd[d]}) begin
        errors++;
        $display("FAIL %s_flags dut%0d: got done=%b es=%b eo=%b, required done=1 es=%b eo=%b",
                 odd_case ? "odd" : "short", d, done_v[d], es_v[d], eo_v[d], exp_short[d], exp_odd[d]);
      end
    end
  endtask

  task automatic test_abort_and_reset(input bit use_reset);
    int base [2];
    new_frame();
    repeat (3) add_line(10, 1'b0);
    base = wr_cnt;
    start = 1; tick(); start = 0;
    if (use_reset) send_frame(-1, -1, 1, 5);
    else           send_frame(1, 2, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wr_cnt[d] != cut_cnt[d]) begin
        errors++;
        $display("FAIL %s_late_write dut%0d: got %0d writes after cut, required 0", use_reset ? "reset" : "abort", d, wr_cnt[d] - cut_cnt[d]);
      end
      checks++;
      if ({busy_v[d], done_v[d], den_v[d], wr_en_v[d]} !== 4'b0 ||
          (use_reset && {es_v[d], eo_v[d], wr_addr_v[d], wr_data_v[d]} !== '0)) begin
        errors++;
        $display("FAIL %s_idle dut%0d: got busy=%b done=%b den=%b addr=%h data=%h, required 0",
                 use_reset ? "reset" : "abort", d, busy_v[d], done_v[d], den_v[d], wr_addr_v[d], wr_data_v[d]);
      end
    end
    if (!use_reset) begin
      checks++;
      if (cut_cnt[0] - base[0] != 4) begin
        errors++;
        $display("FAIL abort_pre_writes dut0: got %0d, required 4", cut_cnt[0] - base[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base [2];
    for (int k = 0; k < 6; k++) begin
      new_frame();
      repeat ($urandom_range(1, 4)) add_line($urandom_range(2, 12), 1'b0);
      run_model(0); run_model(1);
      base = wr_cnt;
      start = 1; tick(); start = 0;
      send_frame(-1, -1, -1, -1);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (wr_cnt[d] - base[d] !== exp_n[d]) begin
          errors++;
          $display("FAIL b2b%0d_count dut%0d: got %0d writes, required %0d", k, d, wr_cnt[d] - base[d], exp_n[d]);
        end
        for (int i = 0; i < exp_n[d] && base[d] + i < wr_cnt[d]; i++) begin
          checks++;
          if (got_w[d][base[d] + i] !== exp_w[d][i]) begin
            errors++;
            $display("FAIL b2b%0d_write%0d dut%0d: got %h, required %h", k, i, d, got_w[d][base[d] + i], exp_w[d][i]);
          end
        end
        checks++;
        if ({done_v[d], es_v[d], eo_v[d]} !== {1'b1, exp_short[d], exp_odd[d]}) begin
          errors++;
          $display("FAIL b2b%0d_flags dut%0d: got done=%b es=%b eo=%b, required done=1 es=%b eo=%b",
                   k, d, done_v[d], es_v[d], eo_v[d], exp_short[d], exp_odd[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_arm_midframe();
    test_short_and_odd(1'b0);
    test_short_and_odd(1'b1);
    test_abort_and_reset(1'b0);
    test_abort_and_reset(1'b1);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
